// File: rtl/paged_bcd_display.sv
// Paged BCD display sequencer: snapshots a wide packed-BCD value and shows it one page at a time, MS page first.
// Optional LEAD_ZERO_BLANK_EN: leading zeros are replaced with blank (4'hF) when the snapshot is captured.
module paged_bcd_display #(
    parameter int unsigned DIGITS_PER_PAGE = 3,
    parameter int unsigned NUM_PAGES       = 3,
    parameter int unsigned DWELL_CYCLES    = 50000000
) (
    input  logic                                   CLOCK_50,
    input  logic                                   rst_n,
    input  logic [4*DIGITS_PER_PAGE*NUM_PAGES-1:0] bcd_in,
    input  logic                                   load,
    input  logic                                   pause,
    output logic [4*DIGITS_PER_PAGE-1:0]           seg_bcd,
    output logic [$clog2(NUM_PAGES+1)-1:0]         page_idx,
    output logic                                   frame_start
);

    localparam int unsigned PAGE_W     = 4 * DIGITS_PER_PAGE;
    localparam int unsigned SNAP_W     = PAGE_W * NUM_PAGES;
    localparam int unsigned NUM_DIGITS = DIGITS_PER_PAGE * NUM_PAGES;
    localparam int unsigned PW         = $clog2(NUM_PAGES + 1);
    localparam int unsigned CW         = $clog2(DWELL_CYCLES);

    localparam logic [PW-1:0] BLANK    = '0;
    localparam logic [PW-1:0] TOP_PAGE = PW'(NUM_PAGES);
    localparam logic [CW-1:0] TERM     = CW'(DWELL_CYCLES - 1);

    logic [SNAP_W-1:0] snapshot, snapshot_nxt;
    logic [SNAP_W-1:0] capture_c;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [PW-1:0]     page_nxt, adv_page;
    logic [PAGE_W-1:0] seg_nxt, adv_seg;
    logic              frame_start_nxt;

`ifdef LEAD_ZERO_BLANK_EN
    // Blank zeros from the MS digit down until the first nonzero; digit 0 always survives.
    always_comb begin
        logic leading;
        leading   = 1'b1;
        capture_c = bcd_in;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            if (leading && bcd_in[4*i +: 4] == 4'h0) begin
                capture_c[4*i +: 4] = 4'hF;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign capture_c = bcd_in;
`endif

    // Page that follows the current one, and its digits taken from the snapshot.
    always_comb begin
        adv_page = (page_idx == BLANK) ? TOP_PAGE : PW'(page_idx - 1'b1);
        adv_seg  = '1;
        for (int unsigned k = 1; k <= NUM_PAGES; k++) begin
            if (adv_page == PW'(k)) begin
                adv_seg = snapshot[PAGE_W*(k-1) +: PAGE_W];
            end
        end
    end

    // Next-state: load beats everything, pause freezes, terminal count advances.
    always_comb begin
        snapshot_nxt    = snapshot;
        page_nxt        = page_idx;
        cnt_nxt         = cnt;
        seg_nxt         = seg_bcd;
        frame_start_nxt = 1'b0;
        if (load) begin
            snapshot_nxt    = capture_c;
            page_nxt        = BLANK;
            cnt_nxt         = '0;
            seg_nxt         = '1;
            frame_start_nxt = 1'b1;
        end else if (!pause) begin
            if (cnt == TERM) begin
                cnt_nxt         = '0;
                page_nxt        = adv_page;
                seg_nxt         = adv_seg;
                frame_start_nxt = (adv_page == BLANK);
            end else begin
                cnt_nxt = CW'(cnt + 1'b1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            snapshot    <= '0;
            page_idx    <= BLANK;
            cnt         <= '0;
            seg_bcd     <= '1;
            frame_start <= 1'b0;
        end else begin
            snapshot    <= snapshot_nxt;
            page_idx    <= page_nxt;
            cnt         <= cnt_nxt;
            seg_bcd     <= seg_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: tb/tb_paged_bcd_display.sv
// Scoreboard bench for paged_bcd_display (D=3, P=3, dwell=4); expectations follow LEAD_ZERO_BLANK_EN.
module tb_paged_bcd_display;

    localparam int unsigned D   = 3;
    localparam int unsigned P   = 3;
    localparam int unsigned DW  = 4;
`ifdef LEAD_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    typedef struct packed {
        logic [11:0] seg;
        logic [1:0]  page;
        logic        fs;
        logic        fs_chk;
    } exp_t;

    logic        CLOCK_50 = 1'b0;
    logic        rst_n;
    logic [35:0] bcd_in;
    logic        load;
    logic        pause;
    logic [11:0] seg_bcd;
    logic [1:0]  page_idx;
    logic        frame_start;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    paged_bcd_display #(
        .DIGITS_PER_PAGE(D),
        .NUM_PAGES      (P),
        .DWELL_CYCLES   (DW)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .load       (load),
        .pause      (pause),
        .seg_bcd    (seg_bcd),
        .page_idx   (page_idx),
        .frame_start(frame_start)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic void check(input string name, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endfunction

    // Monitor: one expected entry per clock, compared at the falling edge.
    always @(negedge CLOCK_50) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("seg_bcd", seg_bcd, e.seg);
            check("page_idx", 12'(page_idx), 12'(e.page));
            if (e.fs_chk) check("frame_start", 12'(frame_start), 12'(e.fs));
        end
    end

    task automatic cyc(input logic ld, input logic ps, input logic [35:0] v,
                       input logic [11:0] eseg, input logic [1:0] epage,
                       input logic efs, input logic fschk);
        load   = ld;
        pause  = ps;
        bcd_in = v;
        @(posedge CLOCK_50);
        exp_q.push_back('{seg: eseg, page: epage, fs: efs, fs_chk: fschk});
        #1;
    endtask

    // n free-running cycles; bcd_in is junk to show it is ignored without load.
    task automatic run(input int n, input logic [11:0] eseg, input logic [1:0] epage, input logic first_fs);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 36'h7A7B7C7D7, eseg, epage, (i == 0) ? first_fs : 1'b0, 1'b1);
    endtask

    task automatic do_load(input logic [35:0] v);
        cyc(1'b1, 1'b0, v, 12'hFFF, 2'd0, 1'b1, 1'b1);
        run(3, 12'hFFF, 2'd0, 1'b0);
    endtask

    initial begin
        rst_n  = 1'b0;
        load   = 1'b0;
        pause  = 1'b0;
        bcd_in = '0;
        exp_q.push_back('{seg: 12'hFFF, page: 2'd0, fs: 1'b0, fs_chk: 1'b1});
        @(negedge CLOCK_50);
        #1;
        rst_n = 1'b1;

        // Basic sequence, then a natural wrap with frame_start.
        do_load(36'h000120345);
        run(4, LZ ? 12'hFFF : 12'h000, 2'd3, 1'b0);
        run(4, 12'h120, 2'd2, 1'b0);
        run(4, 12'h345, 2'd1, 1'b0);
        run(4, 12'hFFF, 2'd0, 1'b1);

        // Pause two cycles into page 2 for 10 cycles.
        run(4, LZ ? 12'hFFF : 12'h000, 2'd3, 1'b0);
        run(2, 12'h120, 2'd2, 1'b0);
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 1'b1, 36'h555555555, 12'h120, 2'd2, 1'b0, 1'b1);
        run(2, 12'h120, 2'd2, 1'b0);
        run(4, 12'h345, 2'd1, 1'b0);
        run(4, 12'hFFF, 2'd0, 1'b1);

        // Load on the terminal-count cycle of page 3.
        run(3, LZ ? 12'hFFF : 12'h000, 2'd3, 1'b0);
        do_load(36'h999999999);
        run(4, 12'h999, 2'd3, 1'b0);
        run(2, 12'h999, 2'd2, 1'b0);

        // Asynchronous reset mid-page, checked before any clock edge.
        @(negedge CLOCK_50);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_seg", seg_bcd, 12'hFFF);
        check("reset_page", 12'(page_idx), 12'd0);
        check("reset_fs", 12'(frame_start), 12'd0);
        #1;
        rst_n = 1'b1;

        // Non-BCD digits pass through.
        do_load(36'hABC0DE012);
        run(4, 12'hABC, 2'd3, 1'b0);
        run(4, 12'h0DE, 2'd2, 1'b0);
        run(4, 12'h012, 2'd1, 1'b0);
        run(1, 12'hFFF, 2'd0, 1'b1);

        // All-zero input.
        do_load(36'h000000000);
        run(4, LZ ? 12'hFFF : 12'h000, 2'd3, 1'b0);
        run(4, LZ ? 12'hFFF : 12'h000, 2'd2, 1'b0);
        run(4, LZ ? 12'hFF0 : 12'h000, 2'd1, 1'b0);

        // Back-to-back loads: the last one wins.
        cyc(1'b1, 1'b0, 36'h888888888, 12'hFFF, 2'd0, 1'b1, 1'b1);
        do_load(36'h456000789);
        run(4, 12'h456, 2'd3, 1'b0);
        run(4, 12'h000, 2'd2, 1'b0);
        run(1, 12'h789, 2'd1, 1'b0);

        // Load while paused: hold on blank until pause drops.
        cyc(1'b1, 1'b1, 36'h111222333, 12'hFFF, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b1, 36'h444444444, 12'hFFF, 2'd0, 1'b0, 1'b1);
        run(3, 12'hFFF, 2'd0, 1'b0);
        run(4, 12'h111, 2'd3, 1'b0);
        run(1, 12'h222, 2'd2, 1'b0);

        @(negedge CLOCK_50);
        #1;
        check("queue_drained", 12'(exp_q.size()), 12'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/paged_bcd_display.md
Name: paged_bcd_display

Overview:
Parametrised multi-page BCD display sequencer for the board seven-segment digits. It captures a wide packed-BCD result into a snapshot and shows it one page at a time on a fixed group of digits, most-significant page first. Each frame starts with an all-blank separator page. Per-digit BCD outputs feed the existing BCD_2_7Seg decoders; code 4'hF means a blank digit.

Parameters:
DIGITS_PER_PAGE, 3, digits shown at once (>=1)
NUM_PAGES, 3, pages per frame excluding the blank page (>=1)
DWELL_CYCLES, 50000000, clock cycles each page is held (>=2; 1 s at 50 MHz)

Ports:
CLOCK_50  in  1  system clock, all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
bcd_in  in  4*DIGITS_PER_PAGE*NUM_PAGES  packed BCD value; digit 0 in bits [3:0]
load  in  1  one-cycle strobe: capture bcd_in and restart the frame
pause  in  1  level: freeze on the current page
seg_bcd  out  4*DIGITS_PER_PAGE  registered digits of the current page; [3:0] = rightmost digit
page_idx  out  clog2(NUM_PAGES+1)  0 = blank page; k = page k, where page NUM_PAGES is most significant
frame_start  out  1  one-cycle pulse when the blank page is entered

Behaviour:
- Reset (asynchronous, rst_n=0):
  - snapshot=0, state=BLANK, page_idx=0
  - seg_bcd=all 4'hF
  - dwell counter=0, frame_start=0
- Page order: BLANK -> page NUM_PAGES -> ... -> page 1 -> BLANK, repeating.
  - Page k shows snapshot digits [k*D-1 : (k-1)*D], where D=DIGITS_PER_PAGE.
- Dwell counter:
  - Counts 0..DWELL_CYCLES-1 while pause=0.
  - On the terminal count it returns to 0 and the state advances.
  - On that same edge, seg_bcd and page_idx are loaded with the next page's content. No output glitch, latency 0 relative to the state.
  - Each page is therefore visible for exactly DWELL_CYCLES cycles.
- pause=1: counter, state and outputs hold. On release, counting resumes from the held count.
- load=1:
  - Snapshot <= bcd_in on that edge.
  - Next edge state=BLANK, counter=0, seg_bcd=all F, page_idx=0, frame_start=1 for one cycle.
  - load has priority over the dwell terminal count.
  - load also acts while pause=1; the block then holds on BLANK until pause drops.
- Changes on bcd_in without load have no effect.
- frame_start also pulses on each natural wrap from page 1 to BLANK. It never pulses while paused.
- Non-BCD input digits (A-E) pass through unchanged. F always displays blank.
- Back-to-back load strobes: each one re-captures and restarts; the last one wins.

Optional Feature:
LEAD_ZERO_BLANK_EN
- Defined:
  - At capture, zero digits are replaced with 4'hF, scanning from the most-significant digit down.
  - The scan stops at the first nonzero digit.
  - Digit 0 is never blanked.
  - The replacement is stored in the snapshot, so it costs no extra display latency.
  - A fully zero input shows blanks everywhere except a single 0 in the rightmost digit of page 1.
- Undefined: the snapshot stores bcd_in verbatim; zeros display as 0.

Test Plan:
All scenarios use DIGITS_PER_PAGE=3, NUM_PAGES=3, DWELL_CYCLES=4.
- Reset: assert rst_n=0 mid-frame -> outputs go to seg_bcd=FFF, page_idx=0, frame_start=0 immediately, without a clock edge.
- Sequence, feature off: load bcd_in=0x000120345 -> frame_start pulse, FFF for 4 cycles, then 000 (page_idx 3), 120 (2), 345 (1), then FFF with frame_start=1; each page lasts 4 cycles.
- Sequence, feature on: same input -> pages show FFF, FFF, 120, 345. All-zero input -> FFF, FFF, FFF, FF0.
- Pause: assert pause at cycle 2 of page 2 for 10 cycles -> page 2 is held 12 cycles total, then 2 more cycles before page 1; no frame_start during the hold.
- Load priority: load new value 0x999999999 on the terminal-count cycle of page 3 -> next cycle state is BLANK (not page 2), then page 3 shows 999.
- Load while paused: pause=1, load 0x111222333 -> BLANK held indefinitely; after pause=0, page 3 shows 111 after 4 cycles.
